mem_wait_responder: RTL and testbench

Word-addressed 32-bit memory responder for the req/gnt memory port of the tiny SoCs. It answers the CPU's instruction or data port with a programmable, optionally pseudo-random number of wait cycles before each grant, so that fuzzing and verification exercise the core's stall paths. The always-granting SRAM model does not exercise those paths. It sits in the SoC top in place of that SRAM, one instance per port.

---
 rtl/mem_resp_pkg.sv | 11 +
 rtl/mem_resp_lfsr.sv | 17 +
 rtl/mem_wait_responder.sv | 112 +++++++++++
 tb/tb_mem_wait_responder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types, FSM states, LFSR taps and strobe helper for mem_wait_responder
package mem_resp_pkg;
  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  strb_t;
  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_e;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic data_t strb_to_mask(strb_t s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/mem_resp_lfsr.sv
// mem_resp_lfsr: seedable 16-bit right-shifting Galois LFSR with enable
module mem_resp_lfsr import mem_resp_pkg::*; #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = en_i ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0)) : lfsr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= Seed;
    else lfsr_q <= lfsr_d;
  end
  assign state_o = lfsr_q;
endmodule

// File: rtl/mem_wait_responder.sv
// mem_wait_responder: req/gnt word memory that inserts fixed or LFSR-drawn wait cycles before each grant
module mem_wait_responder import mem_resp_pkg::*; #(
  parameter int unsigned Depth      = 1 << 16,
  parameter addr_t       BaseAddr   = 32'h80000000,
  parameter int unsigned MaxWait    = 3,
  parameter bit          RandomWait = 1'b1,
  parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  req_i,
  input  addr_t addr_i,
  input  logic  we_i,
  input  data_t wdata_i,
  input  strb_t strb_i,
  output logic  gnt_o,
  output data_t rdata_o,
  output logic  err_o,
  output logic  violation_o
);
  localparam int unsigned Aw = Depth > 1 ? $clog2(Depth) : 1;
  localparam logic [3:0] WaitMask = 4'(MaxWait);
  state_e state_q, state_d;
  addr_t addr_q, addr_d;
  logic we_q, we_d;
  data_t wdata_q, wdata_d;
  strb_t strb_q, strb_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic violation_q, violation_d;
  data_t rdata_q, rdata_d;
  logic [15:0] lfsr;
  logic [3:0] wload;
  addr_t word;
  logic oor, grant;
  logic [Aw-1:0] idx;
  data_t mask;
  data_t mem [Depth];
  mem_resp_lfsr #(.Seed(LfsrSeed)) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (1'b1),
    .state_o (lfsr)
  );
  // Unsigned subtraction makes addresses below BaseAddr wrap to huge indices, which then fail the range check.
  assign word  = (addr_q - BaseAddr) >> 2;
  assign oor   = word >= 32'(Depth);
  assign idx   = word[Aw-1:0];
  assign grant = state_q == GRANT;
  assign mask  = strb_to_mask(strb_q);
  assign wload = RandomWait ? (lfsr[3:0] & WaitMask) : WaitMask;
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    wcnt_d      = wcnt_q;
    violation_d = violation_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: if (req_i) begin
        addr_d  = addr_i;
        we_d    = we_i;
        wdata_d = wdata_i;
        strb_d  = strb_i;
        wcnt_d  = wload;
        state_d = wload == 4'd0 ? GRANT : WAIT;
      end
      WAIT: if (!req_i || addr_i != addr_q || we_i != we_q) begin
        violation_d = 1'b1;
        state_d     = IDLE;
      end else begin
        wcnt_d  = wcnt_q - 4'd1;
        state_d = wcnt_q == 4'd1 ? GRANT : WAIT;
      end
      GRANT: begin
        state_d = IDLE;
        rdata_d = we_q ? rdata_q : (oor ? '0 : mem[idx]);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      wcnt_q      <= '0;
      violation_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      wcnt_q      <= wcnt_d;
      violation_q <= violation_d;
      rdata_q     <= rdata_d;
    end
  end
  // Array is deliberately unreset; an async reset drops state_q out of GRANT, which cancels a pending write.
  always_ff @(posedge clk_i) begin
    if (grant && we_q && !oor) mem[idx] <= (mem[idx] & ~mask) | (wdata_q & mask);
  end
  assign gnt_o       = grant;
  assign err_o       = grant && oor;
  assign rdata_o     = rdata_q;
  assign violation_o = violation_q;
endmodule

// File: tb/tb_mem_wait_responder.sv
// tb_mem_wait_responder: directed scoreboard bench; dut0 has fixed waits, dut1 draws waits from the LFSR
module tb_mem_wait_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req, we, gnt, err, viol;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][3:0] strb;
  logic [15:0] m;
  int checks = 0;
  int failures = 0;
  typedef struct {int lat; logic err; logic chk_rd; logic [31:0] rd;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  mem_wait_responder #(.RandomWait(1'b0), .MaxWait(3)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
    .wdata_i(wdata[0]), .strb_i(strb[0]), .gnt_o(gnt[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .violation_o(viol[0])
  );
  mem_wait_responder #(.Depth(1 << 10), .RandomWait(1'b1), .MaxWait(3), .LfsrSeed(16'hACE1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
    .wdata_i(wdata[1]), .strb_i(strb[1]), .gnt_o(gnt[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .violation_o(viol[1])
  );
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 16'hACE1;
    else m <= {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic access(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] s, input int exp_lat, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd, input string tag, output int lat_o);
    exp_t e;
    int lat = -1;
    sb.push_back('{exp_lat, exp_err, chk_rd, exp_rd});
    req[d] = 1'b1; addr[d] = a; we[d] = w; wdata[d] = wd; strb[d] = s;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (gnt[d]) lat = n;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_err"}, 32'(err[d]), 32'(e.err));
    @(posedge clk); #1;
    req[d] = 1'b0;
    if (e.chk_rd) chk({tag, "_rdata"}, rdata[d], e.rd);
    lat_o = lat;
  endtask
  initial begin
    int lo, cnt, el, bad;
    int hist[5];
    req = '0; we = '0; addr = '0; wdata = '0; strb = '0;
    hist = '{default: 0};
    bad = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt[0]), 0);
    chk("rst_err", 32'(err[0]), 0);
    chk("rst_viol", 32'(viol[0]), 0);
    chk("rst_rdata", rdata[0], 0);
    @(posedge clk); #1;
    access(0, 32'h80000010, 1'b1, 32'hDEADBEEF, 4'hF, 4, 1'b0, 1'b0, 0, "wr_beef", lo);
    access(0, 32'h80000010, 1'b0, 0, 4'hF, 4, 1'b0, 1'b1, 32'hDEADBEEF, "rd_beef", lo);
    dut0.mem[8] = 32'h11223344;
    access(0, 32'h80000020, 1'b1, 32'hAABBCCDD, 4'b0101, 4, 1'b0, 1'b0, 0, "wr_strb", lo);
    access(0, 32'h80000020, 1'b0, 0, 4'hF, 4, 1'b0, 1'b1, 32'h11BB33DD, "rd_strb", lo);
    access(0, 32'h7FFFFFFC, 1'b0, 0, 4'hF, 4, 1'b1, 1'b1, 32'h0, "rd_wrap", lo);
    dut0.mem[0] = 32'h12345678;
    access(0, 32'h80040000, 1'b1, 32'h0, 4'hF, 4, 1'b1, 1'b0, 0, "wr_oor", lo);
    access(0, 32'h80000000, 1'b0, 0, 4'hF, 4, 1'b0, 1'b1, 32'h12345678, "rd_after_oor", lo);
    req[0] = 1'b1; addr[0] = 32'h80000030; we[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (gnt[0]) cnt++;
    end
    chk("viol_nognt", 32'(cnt), 0);
    chk("viol_set", 32'(viol[0]), 1);
    dut0.mem[12] = 32'hCAFEF00D;
    @(posedge clk); #1;
    access(0, 32'h80000030, 1'b0, 0, 4'hF, 4, 1'b0, 1'b1, 32'hCAFEF00D, "after_viol", lo);
    chk("viol_sticky", 32'(viol[0]), 1);
    for (int i = 0; i < 1000; i++) begin
      el = 1 + int'(m[1:0]);
      access(1, 32'h80000000 + 32'(i % 1024) * 4, 1'b0, 0, 4'hF, el, 1'b0, 1'b0, 0, "rnd", lo);
      if (lo >= 1 && lo <= 4) hist[lo]++;
      else bad++;
    end
    chk("rnd_range", 32'(bad), 0);
    for (int k = 1; k <= 4; k++) chk($sformatf("rnd_hist%0d", k), 32'(hist[k] > 0), 1);
    dut0.mem[0] = 32'h0;
    req[0] = 1'b1; addr[0] = 32'h80000000; we[0] = 1'b1; wdata[0] = 32'hFFFFFFFF; strb[0] = 4'hF;
    cnt = 0;
    for (int n = 0; n < 40 && cnt == 0; n++) begin
      @(negedge clk);
      if (gnt[0]) cnt = 1;
    end
    chk("rstg_gnt_seen", 32'(cnt), 1);
    #1 rst_n = 1'b0;
    req[0] = 1'b0;
    #1;
    chk("rstg_gnt", 32'(gnt[0]), 0);
    chk("rstg_err", 32'(err[0]), 0);
    chk("rstg_viol", 32'(viol[0]), 0);
    chk("rstg_rdata", rdata[0], 0);
    repeat (3) @(negedge clk);
    chk("rstg_hold_gnt", 32'(gnt[0]), 0);
    chk("rstg_hold_viol", 32'(viol[0]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 32'h80000000, 1'b0, 0, 4'hF, 4, 1'b0, 1'b1, 32'h0, "rstg_word", lo);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
